// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen
// Brief   : Fetch-stage program-counter generator with flush/branch redirect,
//           sequential increment and a held (pending) branch redirect.
// Revision: 1.0 - initial release
// ============================================================================
module pc_gen #(
   parameter int unsigned        ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
   parameter int unsigned        INST_BYTES   = 4,
   parameter int unsigned        STALL_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  flush_pc_i,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic               imem_ready_i,
   output logic [ADDR_W-1:0]  pc_o,
   output logic               ce_o,
   output logic               pc_valid_o,
   output logic               redirect_pending_o,
   output logic               misalign_o
);

   localparam logic [ADDR_W-1:0] c_low_mask = ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] c_inc      = ADDR_W'(INST_BYTES);

   logic              ce_q,       ce_d;
   logic [ADDR_W-1:0] pc_q,       pc_d;
   logic              pend_q,     pend_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              misalign_q, misalign_d;

   logic              w_adv;
   logic              w_load;
   logic [ADDR_W-1:0] w_load_tgt;

   // Only stall[0] gates fetch; the upper stall bits belong to later stages.
   logic unused_stall;
   assign unused_stall = ^stall;

   assign w_adv = ce_q & ~stall[0] & imem_ready_i;

   always_comb begin
      ce_d       = ce_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      misalign_d = 1'b0;
      w_load     = 1'b0;
      w_load_tgt = '0;

      if (!ce_q) begin
         ce_d = 1'b1;
      end else if (flush_i) begin
         w_load     = 1'b1;
         w_load_tgt = flush_pc_i;
      end else if (w_adv && branch_flag_i) begin
         w_load     = 1'b1;
         w_load_tgt = branch_target_i;
      end else if (w_adv && pend_q) begin
         w_load     = 1'b1;
         w_load_tgt = pend_tgt_q;
      end else if (w_adv) begin
         pc_d = pc_q + c_inc;
      end else if (branch_flag_i) begin
         // Raw target is kept so a misaligned branch still pulses when applied.
         pend_d     = 1'b1;
         pend_tgt_d = branch_target_i;
      end

      if (w_load) begin
         pc_d       = w_load_tgt & ~c_low_mask;
         misalign_d = |(w_load_tgt & c_low_mask);
         pend_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q       <= 1'b0;
         pc_q       <= RESET_VECTOR;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         ce_q       <= ce_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o               = pc_q;
   assign ce_o               = ce_q;
   assign redirect_pending_o = pend_q;
   assign pc_valid_o         = ce_q & ~pend_q;
   assign misalign_o         = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_gen
// Brief   : Scoreboard bench for pc_gen: directed scenarios plus random traffic
//           against a behavioural fetch-address model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_gen;

   localparam int unsigned        ADDR_W       = 32;
   localparam logic [ADDR_W-1:0]  RESET_VECTOR = 32'h100;
   localparam int unsigned        INST_BYTES   = 4;
   localparam int unsigned        STALL_W      = 6;

   typedef struct packed {
      logic [31:0] pc;
      logic        ce;
      logic        pend;
      logic        valid;
      logic        mis;
   } exp_t;

   logic               clk;
   logic               rst;
   logic [STALL_W-1:0] stall;
   logic               flush_i;
   logic [ADDR_W-1:0]  flush_pc_i;
   logic               branch_flag_i;
   logic [ADDR_W-1:0]  branch_target_i;
   logic               imem_ready_i;
   logic [ADDR_W-1:0]  pc_o;
   logic               ce_o;
   logic               pc_valid_o;
   logic               redirect_pending_o;
   logic               misalign_o;

   int total;
   int bad;
   exp_t exp_q[$];

   // Reference model state: pending redirect is a queue of at most one target.
   logic        m_ce;
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_pend[$];

   pc_gen #(
      .ADDR_W       (ADDR_W),
      .RESET_VECTOR (RESET_VECTOR),
      .INST_BYTES   (INST_BYTES),
      .STALL_W      (STALL_W)
   ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .stall              (stall),
      .flush_i            (flush_i),
      .flush_pc_i         (flush_pc_i),
      .branch_flag_i      (branch_flag_i),
      .branch_target_i    (branch_target_i),
      .imem_ready_i       (imem_ready_i),
      .pc_o               (pc_o),
      .ce_o               (ce_o),
      .pc_valid_o         (pc_valid_o),
      .redirect_pending_o (redirect_pending_o),
      .misalign_o         (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: the DUT presents a new fetch state every cycle; pop and compare.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc_o", pc_o, e.pc);
         chk("ce_o", 32'(ce_o), 32'(e.ce));
         chk("redirect_pending_o", 32'(redirect_pending_o), 32'(e.pend));
         chk("pc_valid_o", 32'(pc_valid_o), 32'(e.valid));
         chk("misalign_o", 32'(misalign_o), 32'(e.mis));
      end
   end

   task automatic model_load(input logic [31:0] tgt);
      m_pc  = (tgt / INST_BYTES) * INST_BYTES;
      m_mis = (tgt % INST_BYTES) != 0;
      m_pend.delete();
   endtask

   task automatic model_step(input bit r, input logic [5:0] st, input bit fl,
                             input logic [31:0] fpc, input bit br,
                             input logic [31:0] bt, input bit rdy);
      bit adv;
      m_mis = 1'b0;
      adv   = m_ce && !st[0] && rdy;
      if (r) begin
         m_ce = 1'b0;
         m_pc = RESET_VECTOR;
         m_pend.delete();
      end else if (!m_ce) begin
         m_ce = 1'b1;
      end else if (fl) begin
         model_load(fpc);
      end else if (adv && br) begin
         model_load(bt);
      end else if (adv && m_pend.size() > 0) begin
         model_load(m_pend[0]);
      end else if (adv) begin
         m_pc = m_pc + INST_BYTES;
      end else if (br) begin
         m_pend.delete();
         m_pend.push_back(bt);
      end
   endtask

   task automatic step(input bit r, input logic [5:0] st, input bit fl,
                       input logic [31:0] fpc, input bit br,
                       input logic [31:0] bt, input bit rdy);
      exp_t e;
      @(negedge clk);
      #2;
      rst             = r;
      stall           = st;
      flush_i         = fl;
      flush_pc_i      = fpc;
      branch_flag_i   = br;
      branch_target_i = bt;
      imem_ready_i    = rdy;
      model_step(r, st, fl, fpc, br, bt, rdy);
      e.pc    = m_pc;
      e.ce    = m_ce;
      e.pend  = m_pend.size() > 0;
      e.valid = m_ce && (m_pend.size() == 0);
      e.mis   = m_mis;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ce  = 1'b0;
      m_pc  = RESET_VECTOR;
      m_mis = 1'b0;
      rst = 1'b1; stall = '0; flush_i = 1'b0; flush_pc_i = '0;
      branch_flag_i = 1'b0; branch_target_i = '0; imem_ready_i = 1'b1;

      // Reset and start-up: 100,100,104,108
      step(1, 6'h0, 0, 32'h0, 0, 32'h0, 1);
      run(3);

      // Branch held during a stall, applied on release
      step(0, 6'h1, 0, 32'h0, 0, 32'h0, 1);
      step(0, 6'h3, 0, 32'h0, 1, 32'h2000, 1);
      step(0, 6'h1, 0, 32'h0, 0, 32'h0, 1);
      run(2);

      // Flush beats stall and a pending branch
      step(0, 6'h1, 0, 32'h0, 1, 32'h2000, 1);
      step(0, 6'h1, 1, 32'h80, 0, 32'h0, 1);
      run(1);

      // Newer held branch overwrites older; not-ready also blocks advance
      step(0, 6'h0, 0, 32'h0, 1, 32'h3000, 0);
      step(0, 6'h0, 0, 32'h0, 1, 32'h4002, 0);
      step(0, 6'h0, 0, 32'h0, 0, 32'h0, 1);
      run(1);

      // Live branch wins over an older pending one
      step(0, 6'h1, 0, 32'h0, 1, 32'h5000, 1);
      step(0, 6'h0, 0, 32'h0, 1, 32'h6000, 1);

      // Misaligned branch target
      step(0, 6'h0, 0, 32'h0, 1, 32'h1006, 1);
      run(2);

      // Misaligned flush target
      step(0, 6'h0, 1, 32'h7003, 0, 32'h0, 1);
      run(1);

      // Wrap at top of address space
      step(0, 6'h0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
      run(2);

      // Reset while a redirect is pending, then restart
      step(0, 6'h1, 0, 32'h0, 1, 32'h9000, 1);
      step(1, 6'h1, 0, 32'h0, 0, 32'h0, 1);
      step(0, 6'h0, 0, 32'h0, 1, 32'hA000, 1);
      run(3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 59) == 0,
              6'($urandom),
              $urandom_range(0, 19) == 0,
              $urandom,
              $urandom_range(0, 4) == 0,
              $urandom,
              $urandom_range(0, 3) != 0);
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
